// File: rtl/fifo_axil_to_axis.sv
// AXI4-Lite register front end feeding a first-word-fall-through FIFO that drains onto AXI4-Stream.
// Optional low-water interrupt is built when FIFO_AXIL_IRQ_EN is defined; otherwise irq is tied low.
module fifo_axil_to_axis #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int DEPTH              = 16
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [31:0]                   M_AXIS_TDATA,
  output logic                          M_AXIS_TVALID,
  input  logic                          M_AXIS_TREADY,
  output logic                          irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshakes: a channel transfers on the edge where its VALID and READY are both high.
  // READY is registered and pulses one cycle; a new request is accepted only after the
  // previous response (BVALID/RVALID) has been consumed.
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic [7:0]    thresh;
  logic [31:0]   rd_mux;
  logic [31:0]   status;
  logic [1:0]    wsel, rsel;
  logic          wr_en, rd_en, push_req, push, pop, flush, clr_ovf, full, empty;

  assign wsel     = S_AXI_AWADDR[3:2];
  assign rsel     = S_AXI_ARADDR[3:2];
  assign wr_en    = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_en    = S_AXI_ARREADY && S_AXI_ARVALID;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_req = wr_en && (wsel == 2'd0);
  assign push     = push_req && !full;
  assign pop      = M_AXIS_TVALID && M_AXIS_TREADY;
  assign flush    = wr_en && (wsel == 2'd2) && S_AXI_WDATA[0];
  assign clr_ovf  = wr_en && (wsel == 2'd2) && S_AXI_WDATA[1];
  assign status   = {16'h0, 8'(count), 5'h0, ovf, full, empty};

  assign M_AXIS_TVALID = !empty;
  assign M_AXIS_TDATA  = mem[rptr];
  assign S_AXI_RRESP   = 2'b00;

  always_comb begin
    rd_mux = '0;
    case (rsel)
      2'd1:    rd_mux = status;
      2'd3:    rd_mux = {24'h0, thresh};
      default: rd_mux = '0;
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (push) mem[wptr] <= S_AXI_WDATA;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= 2'b00;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      ovf           <= 1'b0;
      thresh        <= '0;
    end else begin
      S_AXI_AWREADY <= !S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID;
      S_AXI_WREADY  <= !S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID;
      if (wr_en) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= (push_req && full) ? 2'b10 : 2'b00;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end

      S_AXI_ARREADY <= !S_AXI_ARREADY && S_AXI_ARVALID && !S_AXI_RVALID;
      if (rd_en) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_mux;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end

      // Flush wins over a pop landing on the same edge; full is judged on the pre-edge count.
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + AW'(1);
        if (pop)  rptr <= rptr + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (!push && pop) count <= count - CW'(1);
      end

      if (push_req && full) ovf <= 1'b1;
      else if (clr_ovf)     ovf <= 1'b0;

      if (wr_en && (wsel == 2'd3)) thresh <= S_AXI_WDATA[7:0];
    end
  end

`ifdef FIFO_AXIL_IRQ_EN
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) irq <= 1'b0;
    else                irq <= (8'(count) <= thresh);
  end
`else
  assign irq = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], thresh};
endmodule

// File: tb/tb_fifo_axil_to_axis.sv
// Directed bench for fifo_axil_to_axis: register vector table, stream scoreboard, corner sequences.
module tb_fifo_axil_to_axis;
  localparam bit IRQ_EN =
`ifdef FIFO_AXIL_IRQ_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1;
  logic        arvalid = 1'b0, rready = 1'b1, tready = 1'b0;
  logic [31:0] wdata = '0;
  logic        awready, wready, bvalid, arready, rvalid, tvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, tdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  fifo_axil_to_axis #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .DEPTH(16)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .M_AXIS_TDATA(tdata), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready),
    .irq(irq)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stream scoreboard: a beat transfers on the posedge following a negedge that saw valid && ready.
  always @(negedge clk) begin
    if (rst_n && tvalid && tready) begin
      if (exp_q.size() == 0) check("stream_unexpected_beat", tdata, 32'hDEAD_BEEF);
      else check("stream_tdata", tdata, exp_q.pop_front());
    end
  end

  // Driver tasks: called at posedge+1, return at posedge+1.
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input bit tready_at_hs,
                           output logic [1:0] resp, output logic tv_before, output logic tv_after);
    logic old_tready;
    int   waited;
    old_tready = tready;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    waited = 0;
    while (!awready && waited < 20) begin
      step(1);
      waited++;
    end
    if (!awready) begin
      check("aw_timeout", {31'h0, awready}, 32'h1);
      awvalid = 1'b0; wvalid = 1'b0;
      resp = 2'bxx; tv_before = 1'bx; tv_after = 1'bx;
    end else begin
      tv_before = tvalid;
      if (tready_at_hs) tready = 1'b1;
      step(1);
      awvalid = 1'b0; wvalid = 1'b0;
      tready = old_tready;
      check("bvalid_after_hs", {31'h0, bvalid}, 32'h1);
      resp = bresp;
      tv_after = tvalid;
    end
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int waited;
    araddr = a; arvalid = 1'b1;
    waited = 0;
    while (!arready && waited < 20) begin
      step(1);
      waited++;
    end
    if (!arready) begin
      check("ar_timeout", {31'h0, arready}, 32'h1);
      arvalid = 1'b0;
      d = 32'hxxxx_xxxx;
    end else begin
      step(1);
      arvalid = 1'b0;
      check("rvalid_after_hs", {31'h0, rvalid}, 32'h1);
      check("rresp_okay", {30'h0, rresp}, 32'h0);
      d = rdata;
    end
  endtask

  task automatic wr_chk(input string name, input logic [3:0] a, input logic [31:0] d,
                        input logic [1:0] exp_resp, input bit tready_at_hs);
    logic [1:0] r;
    logic tb, ta;
    axi_write(a, d, tready_at_hs, r, tb, ta);
    check(name, {30'h0, r}, {30'h0, exp_resp});
    if (a == 4'h0 && exp_resp == 2'b00) exp_q.push_back(d);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 200 && tvalid; i++) step(1);
    check("drain_done", {31'h0, tvalid}, 32'h0);
  endtask

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;   // BRESP for writes, RDATA for reads
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [1:0]  r;
    logic        tb, ta;
    logic        seen_b;

    vecs[0]  = '{0, 4'h4, 32'h0,        32'h0000_0001};
    vecs[1]  = '{0, 4'hC, 32'h0,        32'h0000_0000};
    vecs[2]  = '{1, 4'hC, 32'h0000_01A5, 32'h0};
    vecs[3]  = '{0, 4'hC, 32'h0,        32'h0000_00A5};
    vecs[4]  = '{1, 4'h4, 32'h0000_FFFF, 32'h0};
    vecs[5]  = '{0, 4'h4, 32'h0,        32'h0000_0001};
    vecs[6]  = '{1, 4'h0, 32'h0000_0011, 32'h0};
    vecs[7]  = '{1, 4'h0, 32'h0000_0022, 32'h0};
    vecs[8]  = '{1, 4'h0, 32'h0000_0033, 32'h0};
    vecs[9]  = '{0, 4'h4, 32'h0,        32'h0000_0300};
    vecs[10] = '{0, 4'h0, 32'h0,        32'h0000_0000};
    vecs[11] = '{0, 4'h8, 32'h0,        32'h0000_0000};
    vecs[12] = '{1, 4'hC, 32'h0,        32'h0};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_handshake_outs", {25'h0, awready, wready, bvalid, arready, rvalid, tvalid, irq}, 32'h0);
    check("rst_resp", {28'h0, bresp, rresp}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // Register table with TREADY low; pushes 0x11/0x22/0x33
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].is_wr) wr_chk($sformatf("vec%0d_bresp", i), vecs[i].addr, vecs[i].data, vecs[i].exp[1:0], 1'b0);
      else rd_chk($sformatf("vec%0d_rdata", i), vecs[i].addr, vecs[i].exp);
    end

    // Drain on consecutive cycles
    tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("drain_tvalid%0d", i), {31'h0, tvalid}, 32'h1);
      @(posedge clk);
      #1;
    end
    check("drain_empty_tvalid", {31'h0, tvalid}, 32'h0);
    rd_chk("status_after_drain", 4'h4, 32'h0000_0001);
    tready = 1'b0;

    // Pushed word is visible with BVALID, not before
    axi_write(4'h0, 32'h0000_0044, 1'b0, r, tb, ta);
    exp_q.push_back(32'h0000_0044);
    check("latency_bresp", {30'h0, r}, 32'h0);
    check("latency_tvalid_before", {31'h0, tb}, 32'h0);
    check("latency_tvalid_with_bvalid", {31'h0, ta}, 32'h1);
    check("latency_tdata", tdata, 32'h0000_0044);
    tready = 1'b1;
    wait_empty();
    tready = 1'b0;

    // Overflow at 17 pushes, sticky clear, full push with same-cycle pop still rejected
    for (int i = 0; i < 17; i++)
      wr_chk($sformatf("fill%0d_bresp", i), 4'h0, 32'h100 + i, (i == 16) ? 2'b10 : 2'b00, 1'b0);
    rd_chk("status_full_ovf", 4'h4, 32'h0000_1006);
    wr_chk("clr_ovf_bresp", 4'h8, 32'h2, 2'b00, 1'b0);
    rd_chk("status_full", 4'h4, 32'h0000_1002);
    wr_chk("full_push_pop_bresp", 4'h0, 32'h0000_01FF, 2'b10, 1'b1);
    rd_chk("status_after_push_pop", 4'h4, 32'h0000_0F04);
    wr_chk("clr_ovf2_bresp", 4'h8, 32'h2, 2'b00, 1'b0);

    // Continuous push while draining: pointers wrap, order held by scoreboard
    tready = 1'b1;
    for (int i = 0; i < 20; i++)
      wr_chk($sformatf("wrap%0d_bresp", i), 4'h0, 32'hA000 + i, 2'b00, 1'b0);
    wait_empty();
    rd_chk("status_after_wrap", 4'h4, 32'h0000_0001);
    tready = 1'b0;

    // Flush with 5 entries, pop on the same edge
    for (int i = 0; i < 5; i++)
      wr_chk($sformatf("pre_flush%0d_bresp", i), 4'h0, 32'hF0 + i, 2'b00, 1'b0);
    axi_write(4'h8, 32'h1, 1'b1, r, tb, ta);
    exp_q.delete();
    check("flush_bresp", {30'h0, r}, 32'h0);
    check("flush_tvalid", {31'h0, ta}, 32'h0);
    rd_chk("status_after_flush", 4'h4, 32'h0000_0001);

    // Low-water interrupt while draining, then reset mid-drain
    wr_chk("thresh2_bresp", 4'hC, 32'h2, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++)
      wr_chk($sformatf("irq_fill%0d_bresp", i), 4'h0, 32'hC0 + i, 2'b00, 1'b0);
    step(2);
    check("irq_above_thresh", {31'h0, irq}, 32'h0);
    tready = 1'b1;
    step(1);
    check("irq_count3", {31'h0, irq}, 32'h0);
    step(1);
    check("irq_count2_latency", {31'h0, irq}, 32'h0);
    step(1);
    check("irq_rises", {31'h0, irq}, {31'h0, IRQ_EN});
    rst_n = 1'b0;
    #1;
    check("irq_in_reset", {31'h0, irq}, 32'h0);
    check("tvalid_in_reset", {31'h0, tvalid}, 32'h0);
    exp_q.delete();
    tready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    rd_chk("status_after_reset", 4'h4, 32'h0000_0001);
    rd_chk("thresh_after_reset", 4'hC, 32'h0);

    // Reset between AWREADY and the handshake abandons the write
    awaddr = 4'h0; wdata = 32'h55; awvalid = 1'b1; wvalid = 1'b1;
    step(1);
    check("abandon_awready_seen", {31'h0, awready}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("abandon_awready_reset", {30'h0, awready, wready}, 32'h0);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      seen_b = seen_b | bvalid;
    end
    check("abandon_no_bvalid", {31'h0, seen_b}, 32'h0);
    check("abandon_no_push", {31'h0, tvalid}, 32'h0);

    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
